// File: rtl/ram64_burst_loader.sv
// ============================================================================
// Module   : ram64_burst_loader
// Brief    : Streams up to 64 16-bit words into a RAM64 starting at a base
//            address, with registered RAM write outputs. Optional zero-fill
//            of the whole RAM when RAM64_CLEAR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram64_burst_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  base_addr,
    input  logic [6:0]  length,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [5:0]  ram_address,
    output logic        busy,
    output logic        done
`ifdef RAM64_CLEAR_EN
    ,
    input  logic        clear
`endif
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_write = 3'd1;
    localparam logic [2:0] c_drain = 3'd2;
    localparam logic [2:0] c_done  = 3'd3;
`ifdef RAM64_CLEAR_EN
    localparam logic [2:0] c_clear = 3'd4;
`endif

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [5:0] r_addr;
    logic [6:0] r_remain;
    logic       w_accept;
    logic       w_start;
    logic [6:0] w_len;

    assign w_accept = s_valid && (r_state == c_write);
    // The RAM holds only 64 words, so longer bursts are clamped.
    assign w_len    = (length > 7'd64) ? 7'd64 : length;

`ifdef RAM64_CLEAR_EN
    assign w_start  = (r_state == c_idle) && start && !clear;
`else
    assign w_start  = (r_state == c_idle) && start;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
`ifdef RAM64_CLEAR_EN
                if (clear) begin
                    w_next = c_clear;
                end else
`endif
                if (start) begin
                    w_next = (length == 7'd0) ? c_done : c_write;
                end
            end
            c_write: begin
                if (w_accept && (r_remain == 7'd1)) begin
                    w_next = c_drain;
                end
            end
            c_drain: w_next = c_done;
            c_done:  w_next = c_idle;
`ifdef RAM64_CLEAR_EN
            c_clear: begin
                if (r_addr == 6'd63) begin
                    w_next = c_done;
                end
            end
`endif
            default: w_next = c_idle;
        endcase
    end

    always_comb begin
        s_ready = (r_state == c_write);
        busy    = (r_state != c_idle);
        done    = (r_state == c_done);
    end

    // RAM write port is registered; ram_in/ram_address hold when no write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= 6'd0;
            r_remain    <= 7'd0;
            ram_load    <= 1'b0;
            ram_in      <= 16'd0;
            ram_address <= 6'd0;
        end else begin
            ram_load <= 1'b0;
            if (w_start) begin
                r_addr   <= base_addr;
                r_remain <= w_len;
            end
`ifdef RAM64_CLEAR_EN
            if ((r_state == c_idle) && clear) begin
                r_addr <= 6'd0;
            end
            if (r_state == c_clear) begin
                ram_load    <= 1'b1;
                ram_in      <= 16'd0;
                ram_address <= r_addr;
                r_addr      <= r_addr + 6'd1;
            end
`endif
            if (w_accept) begin
                ram_load    <= 1'b1;
                ram_in      <= s_data;
                ram_address <= r_addr;
                r_addr      <= r_addr + 6'd1;
                r_remain    <= r_remain - 7'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/ram64_burst_loader.md
RAM64_BURST_LOADER -- requirements
Module: ram64_burst_loader

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- base_addr  input  6  first RAM64 word address of the burst; sampled with start.
- length  input  7  number of words in the burst; sampled with start.
- s_data  input  16  stream write data.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts s_data this cycle.
- ram_in  output  16  data to RAM64 in.
- ram_load  output  1  write strobe to RAM64 load.
- ram_address  output  6  address to RAM64 address.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- clear  input  1  start zero-fill; present only with RAM64_CLEAR_EN.
REQ-002 SHALL use one clock domain; reset is synchronous and active-low.

Function
REQ-003 SHALL implement the states IDLE, WRITE, DRAIN and DONE (plus CLEAR under REQ-019).
REQ-004 From IDLE with start=1: length 0 -> DONE; otherwise -> WRITE. base_addr is latched; length 65..127 is clamped to 64.
REQ-005 SHALL hold s_ready=1 only in WRITE; a word is accepted on an edge where s_valid=1 and s_ready=1.
REQ-006 The k-th accepted word (k=0..L-1) SHALL be written to address (base_addr+k) mod 64; the address wraps from 63 to 0.
REQ-007 ram_in, ram_load and ram_address SHALL be registered: a word accepted at edge N is presented with ram_load=1 during cycle N+1 and stored by RAM64 at edge N+1.
REQ-008 ram_load SHALL be 0 in any cycle with no accepted word from the previous edge; s_valid gaps insert idle cycles with no writes.
REQ-009 When the L-th word is accepted: WRITE -> DRAIN. DRAIN lasts one cycle, during which the final write is presented. DRAIN -> DONE.
REQ-010 done SHALL be 1 for exactly one cycle, in the DONE state; DONE -> IDLE unconditionally.
REQ-011 The total burst time from start to done, with s_valid held at 1, SHALL be L+2 cycles after the start edge.
REQ-012 start asserted while busy=1 SHALL be ignored; it is not queued.
REQ-013 ram_in and ram_address SHALL hold their last values when ram_load=0.
REQ-014 s_data SHALL pass to ram_in unmodified; no width conversion.

Reset
REQ-015 With rst_n=0 at an edge, the block SHALL enter IDLE, clearing s_ready, ram_load, busy and done to 0 and ram_in and ram_address to 0.
REQ-016 A reset mid-burst SHALL abort the burst with no done pulse and ram_load=0 from the next cycle. Words already written remain in RAM64.
REQ-017 start or clear asserted in the same cycle that rst_n=0 SHALL be ignored.

Configuration
REQ-018 The macro RAM64_CLEAR_EN SHALL gate the clear feature.
REQ-019 When RAM64_CLEAR_EN is defined:
- clear=1 in IDLE -> CLEAR; clear takes priority over a simultaneous start.
- CLEAR writes 0 to addresses 0..63 in order, one per cycle, with ram_load=1 for 64 consecutive cycles.
- CLEAR is followed by DONE (done pulse), with s_ready=0 throughout.
REQ-020 When RAM64_CLEAR_EN is not defined:
- no clear port and no CLEAR state exist.
- behaviour is exactly REQ-003..REQ-017.

Verification
REQ-021 Scenario: base_addr=5, length=3, data 0x1111/0x2222/0x3333 with s_valid held at 1 -> writes to 5,6,7; done at cycle 5 after start; RAM64 readback matches.
REQ-022 Scenario: base_addr=62, length=4 -> writes to 62,63,0,1, with address wrap-around.
REQ-023 Scenario: length=0 -> no ram_load; done in the cycle after start; busy high for 1 cycle.
REQ-024 Scenario: length=100 -> exactly 64 writes, covering all addresses once, starting at base_addr.
REQ-025 Scenario: s_valid toggling 1,0,1,0 during length=2 -> ram_load pulses only after accepts; done after the second write; a start pulse mid-burst is ignored.
REQ-026 Scenario: rst_n=0 after 2 of 4 words -> ram_load=0 next cycle, no done; 2 words persist; busy=0. With RAM64_CLEAR_EN: clear -> all 64 words read 0x0000, done at cycle 65.
